// File: rtl/uart_tx_ctrl.sv
// Frame controller for the UART transmit serializer: sequences start, data,
// optional parity and stop bits, and watches the serializer's done handshake.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  load,
    output logic                  ser_en,
    output logic                  tx_out,
    output logic                  tx_ready,
    output logic                  busy,
    output logic                  ser_err
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] bit_cnt_r;
    logic             par_en_r;
    logic             par_bit_r;
    logic             ser_err_r;
    logic             tx_ready_s;
    logic             accept_s;
    logic             last_bit_s;
    logic             wd_fault_s;

    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    // Handshake decode; reset blocks acceptance even when the state already reads IDLE
    always_comb begin
        tx_ready_s = (state_r == IDLE) || (state_r == STOP);
        accept_s   = data_valid && tx_ready_s && !rst;
        last_bit_s = (bit_cnt_r == LAST_BIT);
        // done must appear exactly on the last data bit and nowhere earlier
        wd_fault_s = (state_r == DATA) && (last_bit_s ? !ser_done : ser_done);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                state_nxt_s = DATA;
            end
            DATA: begin
                if (!last_bit_s) begin
                    state_nxt_s = DATA;
                end else if (par_en_r) begin
                    state_nxt_s = PARITY;
                end else begin
                    state_nxt_s = STOP;
                end
            end
            PARITY: begin
                state_nxt_s = STOP;
            end
            STOP: begin
                if (accept_s) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Frame context captured at acceptance, bit counter and sticky watchdog flag
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r <= {CNT_W{1'b0}};
            par_en_r  <= 1'b0;
            par_bit_r <= 1'b0;
            ser_err_r <= 1'b0;
        end else begin
            if (accept_s) begin
                par_en_r  <= par_en;
                par_bit_r <= calc_parity(p_data, par_typ);
            end
            if ((state_r == DATA) && !last_bit_s) begin
                bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                bit_cnt_r <= {CNT_W{1'b0}};
            end
            if (wd_fault_s) begin
                ser_err_r <= 1'b1;
            end
        end
    end

    // Output decode from registered state
    always_comb begin
        tx_out = 1'b1;
        case (state_r)
            IDLE:    tx_out = 1'b1;
            START:   tx_out = 1'b0;
            DATA:    tx_out = ser_data;
            PARITY:  tx_out = par_bit_r;
            STOP:    tx_out = 1'b1;
            default: tx_out = 1'b1;
        endcase
        load     = accept_s;
        ser_en   = accept_s || (state_r == DATA);
        busy     = (state_r != IDLE);
        tx_ready = tx_ready_s;
        ser_err  = ser_err_r;
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed vector table, hand sequences
// for corner cases, and randomized traffic against a frame-level model.
module tb_uart_tx_ctrl;

    logic       clk;
    logic       rst;
    logic       data_valid;
    logic [7:0] p_data;
    logic       par_en;
    logic       par_typ;
    logic       ser_data;
    logic       ser_done;
    logic       load;
    logic       ser_en;
    logic       tx_out;
    logic       tx_ready;
    logic       busy;
    logic       ser_err;

    int n_cmp  = 0;
    int n_fail = 0;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .p_data     (p_data),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .load       (load),
        .ser_en     (ser_en),
        .tx_out     (tx_out),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .ser_err    (ser_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Serializer model; sd_fault suppresses ser_done entirely
    logic [7:0] sr;
    logic [3:0] sh_cnt;
    logic       sd_fault;

    always @(posedge clk) begin
        if (rst) begin
            sr     <= 8'h00;
            sh_cnt <= 4'd8;
        end else if (load) begin
            sr     <= p_data;
            sh_cnt <= 4'd0;
        end else if (ser_en) begin
            sr     <= sr >> 1;
            sh_cnt <= sh_cnt + 4'd1;
        end
    end

    assign ser_data = sr[0];
    assign ser_done = !sd_fault && (sh_cnt == 4'd7);

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Line bit at frame cycle c (0 = start bit)
    function automatic logic exp_bit(input logic [7:0] d, input logic pe, input logic par, input int c);
        if (c == 0) return 1'b0;
        else if (c <= 8) return d[c-1];
        else if ((c == 9) && pe) return par;
        else return 1'b1;
    endfunction

    logic exp_err;

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input int exp_len, input logic exp_par);
        @(posedge clk); #1;
        data_valid = 1'b1; p_data = d; par_en = pe; par_typ = pt;
        @(negedge clk);
        chk("accept_load", load, 1'b1);
        chk("accept_ready", tx_ready, 1'b1);
        chk("accept_ser_en", ser_en, 1'b1);
        @(posedge clk); #1;
        data_valid = 1'b0; p_data = ~d; par_en = ~pe; par_typ = ~pt;
        for (int c = 0; c < exp_len; c++) begin
            @(negedge clk);
            chk("frame_tx", tx_out, exp_bit(d, pe, exp_par, c));
            chk("frame_busy", busy, 1'b1);
            chk("frame_load", load, 1'b0);
            chk("frame_ser_en", ser_en, (c >= 1) && (c <= 8));
            @(posedge clk); #1;
            par_typ = ~par_typ;
            par_en  = ~par_en;
        end
        @(negedge clk);
        chk("end_busy", busy, 1'b0);
        chk("end_tx", tx_out, 1'b1);
        chk("end_ser_err", ser_err, exp_err);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       pt;
        int         len;
        logic       par;
    } vec_t;

    vec_t tbl[8];

    // Frame-level reference state for the randomized phase
    bit         frame_q[$];
    int         pos;
    logic       m_err;
    logic       prev_load;
    logic       prev_wd;
    logic [7:0] prev_d;
    logic       prev_pe;
    logic       prev_pt;
    logic       idle;
    logic       e_ready;
    logic       e_load;
    logic       in_data;

    initial begin
        tbl[0] = '{8'h9B, 1'b0, 1'b0, 10, 1'b0};
        tbl[1] = '{8'h9B, 1'b1, 1'b0, 11, 1'b1};
        tbl[2] = '{8'h9B, 1'b1, 1'b1, 11, 1'b0};
        tbl[3] = '{8'h00, 1'b1, 1'b0, 11, 1'b0};
        tbl[4] = '{8'hFF, 1'b1, 1'b1, 11, 1'b1};
        tbl[5] = '{8'h55, 1'b0, 1'b1, 10, 1'b0};
        tbl[6] = '{8'h01, 1'b1, 1'b0, 11, 1'b1};
        tbl[7] = '{8'hA5, 1'b1, 1'b1, 11, 1'b1};

        rst = 1'b1; data_valid = 1'b1; p_data = 8'h9B;
        par_en = 1'b0; par_typ = 1'b0; sd_fault = 1'b0; exp_err = 1'b0;

        // Reset held with data_valid high
        repeat (2) begin
            @(negedge clk);
            chk("rst_tx", tx_out, 1'b1);
            chk("rst_busy", busy, 1'b0);
            chk("rst_load", load, 1'b0);
            chk("rst_ser_en", ser_en, 1'b0);
            chk("rst_ser_err", ser_err, 1'b0);
        end
        @(posedge clk); #1;
        rst = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        chk("idle_ready", tx_ready, 1'b1);
        chk("idle_busy", busy, 1'b0);

        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].d, tbl[i].pe, tbl[i].pt, tbl[i].len, tbl[i].par);
        end

        // Back-to-back: A5 held, 3C offered in the STOP cycle
        @(posedge clk); #1;
        data_valid = 1'b1; p_data = 8'hA5; par_en = 1'b0;
        @(negedge clk);
        chk("b2b_load1", load, 1'b1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (c == 9) p_data = 8'h3C;
            @(negedge clk);
            chk("b2b_tx1", tx_out, exp_bit(8'hA5, 1'b0, 1'b0, c));
            chk("b2b_busy1", busy, 1'b1);
            chk("b2b_ready1", tx_ready, c == 9);
            chk("b2b_load_stop", load, c == 9);
        end
        @(posedge clk); #1;
        data_valid = 1'b0; p_data = 8'h00;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("b2b_tx2", tx_out, exp_bit(8'h3C, 1'b0, 1'b0, c));
            chk("b2b_busy2", busy, 1'b1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("b2b_end_busy", busy, 1'b0);

        // Serializer never signals done
        sd_fault = 1'b1; exp_err = 1'b1;
        send_frame(8'h9B, 1'b0, 1'b0, 10, 1'b0);
        sd_fault = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b0, 11, 1'b0);

        // Reset while DATA presents bit_cnt=3
        @(posedge clk); #1;
        data_valid = 1'b1; p_data = 8'hC3; par_en = 1'b0;
        @(posedge clk); #1;
        data_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_pre_ser_en", ser_en, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_tx", tx_out, 1'b1);
        chk("mid_ser_en", ser_en, 1'b0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_ser_err", ser_err, 1'b0);
        exp_err = 1'b0;
        send_frame(8'h55, 1'b0, 1'b0, 10, 1'b0);

        // Randomized traffic against the frame-level model
        frame_q.delete(); pos = 0; m_err = 1'b0;
        prev_load = 1'b0; prev_wd = 1'b0;
        prev_d = 8'h00; prev_pe = 1'b0; prev_pt = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (prev_load) begin
                frame_q.delete();
                frame_q.push_back(1'b0);
                for (int k = 0; k < 8; k++) frame_q.push_back(prev_d[k]);
                if (prev_pe) frame_q.push_back((^prev_d) ^ prev_pt);
                frame_q.push_back(1'b1);
                pos = 0;
            end else if (frame_q.size() != 0) begin
                pos++;
                if (pos == frame_q.size()) begin
                    frame_q.delete();
                    pos = 0;
                end
            end
            m_err = m_err | prev_wd;
            #1;
            data_valid = ($urandom_range(0, 2) == 0);
            p_data     = 8'($urandom);
            par_en     = 1'($urandom);
            par_typ    = 1'($urandom);
            sd_fault   = (i >= 2000) && (i < 2300);
            @(negedge clk);
            idle    = (frame_q.size() == 0);
            e_ready = idle || (pos == frame_q.size() - 1);
            e_load  = data_valid && e_ready;
            in_data = !idle && (pos >= 1) && (pos <= 8);
            prev_wd = in_data && (((pos == 8) && !ser_done) || ((pos < 8) && ser_done));
            chk("rnd_tx", tx_out, idle ? 1'b1 : frame_q[pos]);
            chk("rnd_busy", busy, !idle);
            chk("rnd_ready", tx_ready, e_ready);
            chk("rnd_load", load, e_load);
            chk("rnd_ser_en", ser_en, e_load || in_data);
            chk("rnd_ser_err", ser_err, m_err);
            prev_load = e_load;
            prev_d    = p_data;
            prev_pe   = par_en;
            prev_pt   = par_typ;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
